goal_detector: RTL and testbench

//  Producer end of the scoring interface: watches ball x-position once per frame and emits
//  one-cycle score_left/score_right pulses consumed by the score module. After each goal it

---
 rtl/pong_pkg.sv | 16 +
 rtl/goal_detector_if.sv | 23 ++
 rtl/serve_timer.sv | 25 ++
 rtl/goal_detector.sv | 92 +++++++++
 tb/tb_goal_detector.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: goal-detector state encoding and screen geometry.
package pong_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        SCORED     = 2'd1,
        SERVE_WAIT = 2'd2,
        OVER       = 2'd3
    } gd_state_t;

    localparam int SCREEN_W         = 640;
    localparam int SCREEN_H         = 480;
    localparam int DEF_LEFT_GOAL_X  = 0;
    localparam int DEF_RIGHT_GOAL_X = SCREEN_W - 1;

endpackage

// File: rtl/goal_detector_if.sv
// Scoring link: ball position and game_over in, score/recentre/freeze controls out.
interface goal_detector_if #(
    parameter int X_WIDTH = 10
);
    logic               frame_tick;
    logic [X_WIDTH-1:0] ball_x;
    logic               game_over;
    logic               score_left;
    logic               score_right;
    logic               ball_recenter;
    logic               ball_freeze;
    logic               serve_dir;

    modport master (
        input  frame_tick, ball_x, game_over,
        output score_left, score_right, ball_recenter, ball_freeze, serve_dir
    );

    modport slave (
        output frame_tick, ball_x, game_over,
        input  score_left, score_right, ball_recenter, ball_freeze, serve_dir
    );
endinterface

// File: rtl/serve_timer.sv
// Frame-tick down-counter for the post-goal serve delay; terminal when the count reaches zero.
module serve_timer #(
    parameter int CNT_WIDTH = 8,
    parameter int LOAD      = 59
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic terminal
);
    logic [CNT_WIDTH-1:0] cnt;

    // Stops at zero, so it can never wrap even if ticks keep arriving.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= CNT_WIDTH'(LOAD);
        else if (tick && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign terminal = (cnt == '0);
endmodule

// File: rtl/goal_detector.sv
// Detects goals once per frame, pulses the scorer, then freezes the ball for a serve delay.
// All outputs registered; game_over freezes the ball until reset.
module goal_detector
    import pong_pkg::*;
#(
    parameter int X_WIDTH            = 10,
    parameter int LEFT_GOAL_X        = DEF_LEFT_GOAL_X,
    parameter int RIGHT_GOAL_X       = DEF_RIGHT_GOAL_X,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int CNT_WIDTH          = 8
) (
    input  logic              clk,
    input  logic              reset,
    goal_detector_if.master   bus
);
    localparam logic [1:0] S_PLAY       = PLAY;
    localparam logic [1:0] S_SCORED     = SCORED;
    localparam logic [1:0] S_SERVE_WAIT = SERVE_WAIT;
    localparam logic [1:0] S_OVER       = OVER;

    localparam logic [X_WIDTH-1:0] LEFT_X  = X_WIDTH'(LEFT_GOAL_X);
    localparam logic [X_WIDTH-1:0] RIGHT_X = X_WIDTH'(RIGHT_GOAL_X);

    logic [1:0] state;
    logic       hit_left;
    logic       hit_right;
    logic       timer_tick;
    logic       timer_done;

    assign hit_left   = bus.frame_tick && (bus.ball_x <= LEFT_X);
    assign hit_right  = bus.frame_tick && (bus.ball_x >= RIGHT_X);
    assign timer_tick = (state == S_SERVE_WAIT) && bus.frame_tick && !bus.game_over;

    serve_timer #(
        .CNT_WIDTH (CNT_WIDTH),
        .LOAD      (SERVE_DELAY_FRAMES - 1)
    ) u_serve_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == S_SCORED),
        .tick     (timer_tick),
        .terminal (timer_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_PLAY;
            bus.score_left    <= 1'b0;
            bus.score_right   <= 1'b0;
            bus.ball_recenter <= 1'b0;
            bus.ball_freeze   <= 1'b0;
            bus.serve_dir     <= 1'b0;
        end else begin
            bus.score_left    <= 1'b0;
            bus.score_right   <= 1'b0;
            bus.ball_recenter <= 1'b0;
            case (state)
                S_PLAY: begin
                    if (bus.game_over) begin
                        state           <= S_OVER;
                        bus.ball_freeze <= 1'b1;
                    end else if (hit_left || hit_right) begin
                        // Left goal wins a tie: right player scores, serve goes left.
                        state             <= S_SCORED;
                        bus.score_right   <= hit_left;
                        bus.score_left    <= !hit_left;
                        bus.ball_recenter <= 1'b1;
                        bus.ball_freeze   <= 1'b1;
                        bus.serve_dir     <= !hit_left;
                    end
                end
                S_SCORED: begin
                    state           <= S_SERVE_WAIT;
                    bus.ball_freeze <= 1'b1;
                end
                S_SERVE_WAIT: begin
                    if (bus.game_over) begin
                        state           <= S_OVER;
                        bus.ball_freeze <= 1'b1;
                    end else if (timer_tick && timer_done) begin
                        state           <= S_PLAY;
                        bus.ball_freeze <= 1'b0;
                    end
                end
                default: begin
                    state           <= S_OVER;
                    bus.ball_freeze <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_goal_detector.sv
// Directed bench for goal_detector with a 3-frame serve delay and a pulse-counting score model.
module tb_goal_detector;
    logic clk = 1'b0;
    logic reset;

    goal_detector_if #(.X_WIDTH(10)) bus ();

    goal_detector #(
        .X_WIDTH            (10),
        .LEFT_GOAL_X        (0),
        .RIGHT_GOAL_X       (639),
        .SERVE_DELAY_FRAMES (3),
        .CNT_WIDTH          (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Score-module stand-in: counts pulses seen at each clock edge.
    int left_cnt  = 0;
    int right_cnt = 0;
    int both_cnt  = 0;
    always @(posedge clk) begin
        if (reset) begin
            left_cnt  = 0;
            right_cnt = 0;
        end else begin
            if (bus.score_left)  left_cnt++;
            if (bus.score_right) right_cnt++;
            if (bus.score_left && bus.score_right) both_cnt++;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int x);
        bus.ball_x     = 10'(x);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int sl, input int sr,
                              input int rc, input int fz, input int sd);
        check_val({tag, ".score_left"},    int'(bus.score_left),    sl);
        check_val({tag, ".score_right"},   int'(bus.score_right),   sr);
        check_val({tag, ".ball_recenter"}, int'(bus.ball_recenter), rc);
        check_val({tag, ".ball_freeze"},   int'(bus.ball_freeze),   fz);
        check_val({tag, ".serve_dir"},     int'(bus.serve_dir),     sd);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    initial begin
        int l0, r0;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.ball_x     = 10'd320;
        bus.game_over  = 1'b0;

        // 1: reset and mid-field play
        do_reset(5);
        check_outs("reset", 0, 0, 0, 0, 0);
        repeat (4) begin
            do_tick(320);
            step();
        end
        check_outs("midfield", 0, 0, 0, 0, 0);
        check_val("midfield.pulses", left_cnt + right_cnt, 0);

        // 2: left goal, serve delay of 3 ticks
        do_tick(0);
        check_outs("lgoal.pulse", 0, 1, 1, 1, 0);
        bus.ball_x = 10'd320;
        step();
        check_outs("lgoal.after", 0, 0, 0, 1, 0);
        do_tick(320); step();
        check_val("lgoal.tick1.freeze", int'(bus.ball_freeze), 1);
        do_tick(320); step();
        check_val("lgoal.tick2.freeze", int'(bus.ball_freeze), 1);
        do_tick(320);
        check_val("lgoal.tick3.freeze", int'(bus.ball_freeze), 0);
        check_val("lgoal.right_cnt", right_cnt, 1);

        // 3: right goal, ball held in goal while frozen
        do_tick(639);
        check_outs("rgoal.pulse", 1, 0, 1, 1, 1);
        repeat (3) begin
            step();
            do_tick(639);
        end
        check_val("rgoal.unfrozen", int'(bus.ball_freeze), 0);
        check_val("rgoal.left_cnt", left_cnt, 1);
        check_val("rgoal.serve_dir_hold", int'(bus.serve_dir), 1);

        // 4: ball_x in goal but no frame_tick
        bus.ball_x = 10'd0;
        l0 = left_cnt; r0 = right_cnt;
        repeat (10) step();
        check_val("notick.pulses", left_cnt + right_cnt - l0 - r0, 0);
        check_val("notick.freeze", int'(bus.ball_freeze), 0);
        do_tick(0);
        check_outs("tick.pulse", 0, 1, 1, 1, 0);
        step();
        check_val("tick.one_pulse", right_cnt - r0, 1);

        // 5: game_over during SERVE_WAIT
        bus.game_over = 1'b1;
        step();
        repeat (5) begin
            do_tick(0);
            step();
        end
        repeat (20) step();
        check_val("over.freeze", int'(bus.ball_freeze), 1);
        check_val("over.pulses", right_cnt - r0, 1);
        bus.game_over = 1'b0;
        do_reset(1);
        check_outs("over.reset", 0, 0, 0, 0, 0);

        // 6: reset during SCORED, then during SERVE_WAIT
        do_tick(0);
        reset = 1'b1;
        step();
        check_outs("rst_scored", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        do_tick(639);
        step();
        check_val("rst_wait.pre_freeze", int'(bus.ball_freeze), 1);
        do_reset(1);
        check_outs("rst_wait", 0, 0, 0, 0, 0);
        do_tick(320);
        check_val("rst_wait.play", int'(bus.ball_freeze), 0);

        // Chained scoring: 3 left goals
        repeat (3) begin
            do_tick(639);
            step();
            repeat (3) begin
                do_tick(320);
                step();
            end
        end
        check_val("chain.left_score_out", left_cnt, 3);
        check_val("chain.right_score_out", right_cnt, 0);
        check_val("chain.unfrozen", int'(bus.ball_freeze), 0);
        check_val("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
